ram_ctrl_74189: RTL and testbench

- Synchronous initiator-side controller for the CPU's 16x8 RAM, built from two 16x4 active-low-strobe, output-inverting RAM chips (low nibble and high nibble).
- Converts a valid/ready CPU request (read or write) into correctly sequenced chip-select, write-enable, address and data, with setup and hold margins.
- Re-inverts the chips' complemented outputs and returns registered read data.
- Sits between the CPU control/bus logic and the RAM chips.

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/ram_ctrl_timer.sv | 26 ++
 rtl/ram_ctrl_74189.sv | 148 ++++++++++++++
 tb/tb_ram_ctrl_74189.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared widths, FSM state codes and timer-load helper for the 16x8 RAM controller.
package ram_ctrl_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] W_SETUP  = 3'd1;
  localparam logic [2:0] W_PULSE  = 3'd2;
  localparam logic [2:0] W_HOLD   = 3'd3;
  localparam logic [2:0] W_VERIFY = 3'd4;
  localparam logic [2:0] R_WAIT   = 3'd5;

  // A phase lasting N cycles ends when the counter, loaded with N-1 on entry, reaches zero.
  function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/ram_ctrl_timer.sv
// Loadable down counter timing the multi-cycle FSM phases; done is high while the count is zero.
module ram_ctrl_timer
  import ram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ram_ctrl_74189.sv
// Valid/ready controller sequencing two 16x4 inverting-output RAM chips as one 16x8 memory.
// Optional write read-back verification is enabled by defining RAM_CTRL_READBACK_EN.
module ram_ctrl_74189
  import ram_ctrl_pkg::*;
#(
  parameter int WR_PULSE_CYC = 1,
  parameter int RD_WAIT_CYC  = 1
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              ram_cs_n,
  output logic              ram_we_n,
  output logic [ADDR_W-1:0] ram_a,
  output logic [DATA_W-1:0] ram_d,
  input  logic [DATA_W-1:0] ram_o
);

  logic [2:0]       state;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic [DATA_W-1:0] rd_true;

  assign rd_true   = ~ram_o;
  assign req_ready = (state == IDLE);

  // The timer is loaded on the edge that enters each counted phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE: begin
        if (req_valid && !req_we) begin
          tmr_load = 1'b1;
          tmr_val  = cnt_load(RD_WAIT_CYC);
        end
      end
      W_SETUP: begin
        tmr_load = 1'b1;
        tmr_val  = cnt_load(WR_PULSE_CYC);
      end
`ifdef RAM_CTRL_READBACK_EN
      W_HOLD: begin
        tmr_load = 1'b1;
        tmr_val  = cnt_load(RD_WAIT_CYC);
      end
`endif
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  ram_ctrl_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_cs_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_a     <= '0;
      ram_d     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef RAM_CTRL_READBACK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_a    <= req_addr;
            ram_d    <= req_wdata;
            ram_cs_n <= 1'b0;
            state    <= req_we ? W_SETUP : R_WAIT;
          end
        end
        W_SETUP: begin
          ram_we_n <= 1'b0;
          state    <= W_PULSE;
        end
        W_PULSE: begin
          if (tmr_done) begin
            ram_we_n <= 1'b1;
            state    <= W_HOLD;
          end
        end
        W_HOLD: begin
`ifdef RAM_CTRL_READBACK_EN
          state     <= W_VERIFY;
`else
          ram_cs_n  <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= IDLE;
`endif
        end
`ifdef RAM_CTRL_READBACK_EN
        W_VERIFY: begin
          if (tmr_done) begin
            rsp_rdata <= rd_true;
            rsp_err   <= (rd_true != ram_d);
            ram_cs_n  <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
`endif
        R_WAIT: begin
          if (tmr_done) begin
            rsp_rdata <= rd_true;
`ifdef RAM_CTRL_READBACK_EN
            rsp_err   <= 1'b0;
`endif
            ram_cs_n  <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          ram_cs_n <= 1'b1;
          ram_we_n <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifndef RAM_CTRL_READBACK_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl_74189.sv
// Bench for ram_ctrl_74189: two instances (default timing and WR=3/RD=2), each on a pair of 16x4 chip models.
module tb_ram_ctrl_74189;

`ifdef RAM_CTRL_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  // In read-back builds, high-chip bit 6 (byte bit 6) is stuck at 0 in the memory model.
  localparam logic [7:0] STUCK = RB ? 8'h40 : 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_we    [2];
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       rsp_err   [2];
  logic       cs_n      [2];
  logic       we_n      [2];
  logic [3:0] ram_a     [2];
  logic [7:0] ram_d     [2];
  logic [7:0] ram_o     [2];

  ram_ctrl_74189 dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
    .ram_cs_n(cs_n[0]), .ram_we_n(we_n[0]), .ram_a(ram_a[0]), .ram_d(ram_d[0]), .ram_o(ram_o[0])
  );

  ram_ctrl_74189 #(.WR_PULSE_CYC(3), .RD_WAIT_CYC(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
    .ram_cs_n(cs_n[1]), .ram_we_n(we_n[1]), .ram_a(ram_a[1]), .ram_d(ram_d[1]), .ram_o(ram_o[1])
  );

  // Chip pair model: outputs pulled high when deselected, show complemented input while writing.
  logic [7:0] mem [2][16];
  always @(posedge clk)
    for (int g = 0; g < 2; g++)
      if (!cs_n[g] && !we_n[g]) mem[g][ram_a[g]] <= ram_d[g];

  function automatic logic [7:0] chip_out(input logic cs, input logic we, input logic [7:0] d,
                                          input logic [7:0] m);
    if (cs) return 8'hFF;
    if (!we) return ~d;
    return ~(m & ~STUCK);
  endfunction

  assign ram_o[0] = chip_out(cs_n[0], we_n[0], ram_d[0], mem[0][ram_a[0]]);
  assign ram_o[1] = chip_out(cs_n[1], we_n[1], ram_d[1], mem[1][ram_a[1]]);

  function automatic int wrp(input int g); return (g == 0) ? 1 : 3; endfunction
  function automatic int rdp(input int g); return (g == 0) ? 1 : 2; endfunction
  function automatic int busy_len(input int g, input logic we);
    return we ? (2 + wrp(g) + (RB ? rdp(g) : 0)) : rdp(g);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL inst%0d %s: got %0h expected %0h (t=%0t)", g, nm, act, exp, $time);
    end
  endtask

  // Reference model: k counts busy cycles since accept (0 = idle); the access ends after busy_len cycles.
  int         mk      [2];
  int         mT      [2];
  logic       mwr     [2];
  logic [3:0] ma      [2];
  logic [7:0] md      [2];
  logic       exp_rsp [2];
  logic [7:0] exp_rd  [2];
  logic       exp_err [2];
  logic [7:0] refmem  [2][16];
  int         n_acc   [2];
  int         n_rsp   [2];

  initial for (int g = 0; g < 2; g++) begin n_acc[g] = 0; n_rsp[g] = 0; end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        mk[g] <= 0; mT[g] <= 0; mwr[g] <= 1'b0; ma[g] <= '0; md[g] <= '0;
        exp_rsp[g] <= 1'b0; exp_rd[g] <= '0; exp_err[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        exp_rsp[g] <= 1'b0;
        if (mk[g] != 0 && mk[g] == mT[g]) begin
          exp_rsp[g] <= 1'b1;
          mk[g] <= 0;
          if (!mwr[g]) begin
            exp_rd[g]  <= refmem[g][ma[g]];
            exp_err[g] <= 1'b0;
          end else if (RB) begin
            exp_rd[g]  <= md[g] & ~STUCK;
            exp_err[g] <= ((md[g] & STUCK) != 8'h00);
          end
        end else if (mk[g] != 0) begin
          mk[g] <= mk[g] + 1;
        end else if (req_valid[g]) begin
          mk[g]  <= 1;
          mT[g]  <= busy_len(g, req_we[g]);
          mwr[g] <= req_we[g];
          ma[g]  <= req_addr[g];
          md[g]  <= req_wdata[g];
          if (req_we[g]) refmem[g][req_addr[g]] <= req_wdata[g] & ~STUCK;
          n_acc[g] <= n_acc[g] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      check(g, "req_ready", req_ready[g], mk[g] == 0);
      check(g, "ram_cs_n",  cs_n[g],      mk[g] == 0);
      check(g, "ram_we_n",  we_n[g],      !(mwr[g] && mk[g] >= 2 && mk[g] <= 1 + wrp(g)));
      check(g, "ram_a",     ram_a[g],     ma[g]);
      check(g, "ram_d",     ram_d[g],     md[g]);
      check(g, "rsp_valid", rsp_valid[g], exp_rsp[g]);
      check(g, "rsp_rdata", rsp_rdata[g], exp_rd[g]);
      check(g, "rsp_err",   rsp_err[g],   exp_err[g]);
      if (rsp_valid[g]) n_rsp[g] <= n_rsp[g] + 1;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int g, input logic we, input logic [3:0] a, input logic [7:0] d,
                      output int acc);
    int n = 0;
    req_valid[g] = 1'b1; req_we[g] = we; req_addr[g] = a; req_wdata[g] = d;
    while (!req_ready[g] && n < 200) begin @(posedge clk); #1; n++; end
    if (!req_ready[g]) begin
      errors++; checks++;
      $display("FAIL inst%0d ready_timeout: got req_ready=0 expected 1 within 200 cycles", g);
    end
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic wait_rsp(input int g, input int acc, output int lat, output int wl);
    int n = 0;
    wl = 0;
    while (!rsp_valid[g] && n < 200) begin
      if (!we_n[g]) wl++;
      @(posedge clk); #1; n++;
    end
    if (rsp_valid[g]) lat = cyc - acc;
    else begin
      lat = -1; errors++; checks++;
      $display("FAIL inst%0d rsp_timeout: got no rsp_valid expected one within 200 cycles", g);
    end
  endtask

  int acc, lat, wl, extra, n, mode;

  initial begin
    for (int g = 0; g < 2; g++) begin
      req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = '0; req_wdata[g] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check(0, "rst_ready", req_ready[0], 1);
    check(0, "rst_cs_n",  cs_n[0], 1);
    check(1, "rst_we_n",  we_n[1], 1);
    check(0, "rst_rdata", rsp_rdata[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(0, 1'b1, 4'd3, 8'hA5, acc); req_valid[0] = 1'b0;
    wait_rsp(0, acc, lat, wl);
    check(0, "wr_latency", lat, RB ? 4 : 3);
    check(0, "wr_err", rsp_err[0], 0);
    send(0, 1'b0, 4'd3, 8'h00, acc); req_valid[0] = 1'b0;
    wait_rsp(0, acc, lat, wl);
    check(0, "rd_latency", lat, 1);
    check(0, "rd_data", rsp_rdata[0], 8'hA5);

    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 16; i++) send(g, 1'b1, 4'(i), 8'(i * 17), acc);
      for (int i = 0; i < 16; i++) send(g, 1'b0, 4'(i), 8'h00, acc);
      req_valid[g] = 1'b0;
      repeat (8) @(posedge clk);
      #1;
    end

    send(0, 1'b0, 4'd3, 8'h00, acc); req_valid[0] = 1'b0;
    wait_rsp(0, acc, lat, wl);
    check(0, "fill_rd3", rsp_rdata[0], 8'h33);

    send(0, 1'b1, 4'd7, 8'hFF, acc); req_valid[0] = 1'b0;
    wait_rsp(0, acc, lat, wl);
    check(0, "wr_ff_err", rsp_err[0], RB ? 1 : 0);
    check(0, "wr_ff_rdata", rsp_rdata[0], RB ? 8'hBF : 8'h33);
    send(0, 1'b1, 4'd7, 8'h0F, acc); req_valid[0] = 1'b0;
    wait_rsp(0, acc, lat, wl);
    check(0, "wr_0f_err", rsp_err[0], 0);
    check(0, "wr_0f_rdata", rsp_rdata[0], RB ? 8'h0F : 8'h33);

    send(1, 1'b1, 4'd9, 8'h3C, acc); req_valid[1] = 1'b0;
    wait_rsp(1, acc, lat, wl);
    check(1, "wr_latency", lat, RB ? 7 : 5);
    check(1, "we_low_cycles", wl, 3);
    send(1, 1'b0, 4'd9, 8'h00, acc); req_valid[1] = 1'b0;
    wait_rsp(1, acc, lat, wl);
    check(1, "rd_latency", lat, 2);
    check(1, "rd_data", rsp_rdata[1], 8'h3C);

    // A request raised while busy must be dropped, not queued.
    send(1, 1'b1, 4'd2, 8'h5A, acc);
    req_we[1] = 1'b0; req_addr[1] = 4'd11;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, acc, lat, wl);
    check(1, "busy_wr_latency", lat, RB ? 7 : 5);
    extra = 0;
    repeat (10) begin @(posedge clk); #1; if (rsp_valid[1]) extra++; end
    check(1, "busy_extra_rsp", extra, 0);
    check(0, "rsp_count", n_rsp[0], n_acc[0]);
    check(1, "rsp_count", n_rsp[1], n_acc[1]);

    // Abort a write mid-pulse; it rewrites the value already held so memory stays consistent.
    send(1, 1'b1, 4'd4, 8'h44, acc); req_valid[1] = 1'b0;
    n = 0;
    while (we_n[1] && n < 20) begin @(posedge clk); #1; n++; end
    check(1, "abort_in_pulse", we_n[1], 0);
    #2 rst_n = 1'b0;
    #1;
    check(1, "abort_cs_n", cs_n[1], 1);
    check(1, "abort_we_n", we_n[1], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid[1]) extra++; end
    check(1, "abort_no_rsp", extra, 0);
    check(1, "abort_ready", req_ready[1], 1);

    for (int g = 0; g < 2; g++) begin
      for (int k = 0; k < 40; k++) begin
        send(g, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), acc);
        mode = $urandom_range(0, 2);
        if (mode == 0) begin
          req_valid[g] = 1'b0;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end else if (mode == 2) begin
          req_we[g] = 1'($urandom_range(0, 1)); req_addr[g] = 4'($urandom_range(0, 15));
          @(posedge clk); #1;
          req_valid[g] = 1'b0;
        end
      end
      req_valid[g] = 1'b0;
      repeat (12) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
